// File: rtl/reg_file_pkg.sv
// Shared constants for the architectural register file and NZCV flag register.
package reg_file_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;
  localparam int SP_IDX     = 29;
  localparam int ZERO_IDX   = 0;
  localparam int FLAG_W     = 4;
  localparam int N_BIT      = 3;
  localparam int Z_BIT      = 2;
  localparam int C_BIT      = 1;
  localparam int V_BIT      = 0;
endpackage

// File: rtl/reg_file_nzcv_flag_reg.sv
// Enabled NZCV flag register with asynchronous clear; output is purely registered.
module nzcv_flag_reg
  import reg_file_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [FLAG_W-1:0] d_i,
  output logic [FLAG_W-1:0] q_o
);
  logic [FLAG_W-1:0] r_flags;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     r_flags <= '0;
    else if (en_i) r_flags <= d_i;
  end

  assign q_o = r_flags;
endmodule

// File: rtl/reg_file_nzcv.sv
// Register file with two combinational read ports, one write port and NZCV flags.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file_nzcv
  import reg_file_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                REG_NUM = 32,
  parameter logic [DATA_W-1:0] SP_INIT = 32'd128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] RSaddr_i,
  input  logic [REG_ADDR_W-1:0] RTaddr_i,
  input  logic [REG_ADDR_W-1:0] RDaddr_i,
  input  logic [DATA_W-1:0]     RDdata_i,
  input  logic                  RegWrite_i,
  input  logic [FLAG_W-1:0]     NZCV_i,
  input  logic                  FlagWrite_i,
  output logic [DATA_W-1:0]     RSdata_o,
  output logic [DATA_W-1:0]     RTdata_o,
  output logic [FLAG_W-1:0]     NZCV_o
);
  localparam logic [REG_ADDR_W-1:0] ZERO_A = REG_ADDR_W'(ZERO_IDX);

  logic [REG_NUM-1:0][DATA_W-1:0] r_regs;
  logic                           w_wr_en;
  logic [DATA_W-1:0]              w_rs, w_rt;

  assign w_wr_en = RegWrite_i && (RDaddr_i != ZERO_A);

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_NUM; i++)
        r_regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
    end else if (w_wr_en) begin
      r_regs[RDaddr_i] <= RDdata_i;
    end
  end

  always_comb begin
    w_rs = r_regs[RSaddr_i];
    w_rt = r_regs[RTaddr_i];
`ifdef REG_FILE_BYPASS_EN
    if (w_wr_en && (RSaddr_i == RDaddr_i)) w_rs = RDdata_i;
    if (w_wr_en && (RTaddr_i == RDaddr_i)) w_rt = RDdata_i;
`endif
    if (RSaddr_i == ZERO_A) w_rs = '0;
    if (RTaddr_i == ZERO_A) w_rt = '0;
  end

  assign RSdata_o = w_rs;
  assign RTdata_o = w_rt;

  nzcv_flag_reg u_flags (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (FlagWrite_i),
    .d_i   (NZCV_i),
    .q_o   (NZCV_o)
  );
endmodule

// File: tb/tb_reg_file_nzcv.sv
// Scoreboard bench for reg_file_nzcv: stimulus queues expectations, a monitor compares.
module tb_reg_file_nzcv;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i;
  logic [31:0] RDdata_i;
  logic        RegWrite_i, FlagWrite_i;
  logic [3:0]  NZCV_i;
  logic [31:0] RSdata_o, RTdata_o;
  logic [3:0]  NZCV_o;

  reg_file_nzcv dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
    .RDdata_i(RDdata_i), .RegWrite_i(RegWrite_i),
    .NZCV_i(NZCV_i), .FlagWrite_i(FlagWrite_i),
    .RSdata_o(RSdata_o), .RTdata_o(RTdata_o), .NZCV_o(NZCV_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    int          sel;   // 0 RS port, 1 RT port, 2 flags
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  event chk_ev;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Monitor: output is valid whenever the stimulus strobes chk_ev.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.sel)
          0:       act = RSdata_o;
          1:       act = RTdata_o;
          default: act = {28'd0, NZCV_o};
        endcase
        n_checks++;
        if (act === e.val) n_pass++;
        else $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic push(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name; e.sel = sel; e.val = val;
    q.push_back(e);
  endtask

  task automatic chk();
    -> chk_ev;
    #1;
  endtask

  task automatic cycle();
    @(posedge clk_i);
    #2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    RegWrite_i = 1'b1; RDaddr_i = a; RDdata_i = d;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    RSaddr_i = a; RTaddr_i = b;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; RSaddr_i = '0; RTaddr_i = '0; RDaddr_i = '0; RDdata_i = '0;
    RegWrite_i = 1'b0; FlagWrite_i = 1'b0; NZCV_i = '0;
    cycle();
    rst_i = 1'b0;

    // Populate state so the later asynchronous reset has something to clear.
    wr(5'd1, 32'hAA); FlagWrite_i = 1'b1; NZCV_i = 4'hF;
    cycle();
    wr(5'd31, 32'hBB); FlagWrite_i = 1'b0;
    cycle();
    RegWrite_i = 1'b0;
    rd(5'd1, 5'd31);
    push("pre_r1", 0, 32'hAA); push("pre_r31", 1, 32'hBB); push("pre_flags", 2, 32'hF);
    chk();

    // Mid-cycle reset: effective without a clock edge.
    rst_i = 1'b1;
    #1;
    push("rst_r1", 0, 32'h0); push("rst_r31", 1, 32'h0); push("rst_flags", 2, 32'h0);
    chk();
    rd(5'd29, 5'd0);
    push("rst_sp", 0, 32'd128); push("rst_r0", 1, 32'h0);
    chk();

    // Write across an edge with reset high is dropped; after release it is taken.
    wr(5'd6, 32'h66);
    cycle();
    wr(5'd5, 32'h99);
    rst_i = 1'b0;
    cycle();
    RegWrite_i = 1'b0;
    rd(5'd6, 5'd5);
    push("rst_wr_ignored", 0, 32'h0); push("post_rst_wr", 1, 32'h99);
    chk();

    // Basic write/read.
    wr(5'd5, 32'hDEADBEEF);
    cycle();
    wr(5'd6, 32'h1);
    cycle();
    RegWrite_i = 1'b0;
    rd(5'd5, 5'd6);
    push("rd_r5", 0, 32'hDEADBEEF); push("rd_r6", 1, 32'h1);
    chk();

    // Register 0 discards writes, including on the bypass path.
    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0);
    push("r0_same_rs", 0, 32'h0); push("r0_same_rt", 1, 32'h0);
    chk();
    cycle();
    RegWrite_i = 1'b0;
    rd(5'd0, 5'd0);
    push("r0_after_rs", 0, 32'h0); push("r0_after_rt", 1, 32'h0);
    chk();

    // Same-cycle read of the register being written.
    wr(5'd7, 32'h11);
    cycle();
    wr(5'd7, 32'h55);
    rd(5'd7, 5'd6);
    push("r7_before_edge", 0, BYP ? 32'h55 : 32'h11); push("r6_unbypassed", 1, 32'h1);
    chk();
    cycle();
    RegWrite_i = 1'b0;
    rd(5'd7, 5'd7);
    push("r7_after_rs", 0, 32'h55); push("r7_after_rt", 1, 32'h55);
    chk();

    // Flags: registered capture and hold.
    FlagWrite_i = 1'b1; NZCV_i = 4'b1010;
    #1;
    push("flags_not_comb", 2, 32'h0);
    chk();
    cycle();
    FlagWrite_i = 1'b0; NZCV_i = 4'b0101;
    #1;
    push("flags_capture", 2, 32'hA);
    chk();
    cycle();
    push("flags_hold", 2, 32'hA);
    chk();

    // Flag capture and register write in the same cycle.
    FlagWrite_i = 1'b1; NZCV_i = 4'b0110; wr(5'd8, 32'h88);
    cycle();
    FlagWrite_i = 1'b0; RegWrite_i = 1'b0;
    rd(5'd8, 5'd5);
    push("dual_flags", 2, 32'h6); push("dual_r8", 0, 32'h88); push("dual_r5", 1, 32'hDEADBEEF);
    chk();

    // Reset mid-operation restores SP and drops a write presented during reset.
    wr(5'd29, 32'h77);
    cycle();
    RegWrite_i = 1'b0;
    rd(5'd29, 5'd8);
    push("sp_written", 0, 32'h77); push("r8_held", 1, 32'h88);
    chk();
    rst_i = 1'b1;
    #1;
    push("sp_reset", 0, 32'd128); push("flags_reset", 2, 32'h0);
    chk();
    wr(5'd29, 32'h33);
    cycle();
    RegWrite_i = 1'b0;
    rst_i = 1'b0;
    cycle();
    rd(5'd29, 5'd29);
    push("sp_no_wr_rs", 0, 32'd128); push("sp_no_wr_rt", 1, 32'd128);
    chk();

    #5;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/reg_file_nzcv.md
# reg_file_nzcv

Architectural register file and condition-flag register for the single-cycle CPU. It sits directly upstream of the ALU, supplying source operands on two asynchronous read ports, and directly downstream, capturing the write-back result and the ALU's NZCV flags on the rising clock edge. All architectural state of the datapath other than the PC lives here.

## Interface

Parameters:
- DATA_W, 32, register and data width.
- REG_NUM, 32, number of architectural registers (address width fixed at 5).
- SP_INIT, 32'd128, reset value of the stack pointer, register 29.

Ports:
- clk_i  input  1  system clock, all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- RSaddr_i  input  5  read port A address.
- RTaddr_i  input  5  read port B address.
- RDaddr_i  input  5  write-back address.
- RDdata_i  input  32  write-back data (ALU result or memory load).
- RegWrite_i  input  1  write enable for RDaddr_i/RDdata_i.
- NZCV_i  input  4  flags from the ALU: [3] N, [2] Z, [1] C, [0] V.
- FlagWrite_i  input  1  capture enable for NZCV_i.
- RSdata_o  output  32  read port A data, to ALU source A.
- RTdata_o  output  32  read port B data, to ALU source B and store data.
- NZCV_o  output  4  registered flags, for the branch condition unit.

## Operation

- Storage: REG_NUM × DATA_W registers plus one 4-bit flag register.
- Reset (rst_i high, asynchronous, effective immediately): every register clears to 0 except register 29, which loads SP_INIT. The flag register clears to 4'b0000.
  - While rst_i is high, RSdata_o and RTdata_o reflect the reset contents, and NZCV_o = 0.
  - Writes and flag captures are ignored while rst_i is high.
- Write: on the rising edge, if RegWrite_i = 1 and RDaddr_i ≠ 0, register[RDaddr_i] ← RDdata_i.
- Register 0 is hardwired to zero: writes to it are discarded and reads of it always return 32'd0.
- Read: combinational. RSdata_o = register[RSaddr_i] and RTdata_o = register[RTaddr_i]. Both ports may address the same register.
- Flags: on the rising edge, if FlagWrite_i = 1, flags ← NZCV_i. Otherwise the flags hold their value.
- Flag capture and register write are independent and may occur in the same cycle.
- Deassertion of rst_i takes effect at the next rising edge. A write presented in the same cycle that reset deasserts is performed only if rst_i is already low at that edge.

## Timing

- Read latency: 0 cycles (combinational from address to data).
- Write latency: 1 cycle. Data written at edge N is visible on the read ports after edge N.
- Flag latency: 1 cycle. NZCV_o updates after the capture edge and never changes combinationally with NZCV_i.
- Same-cycle read of the register being written:
  - Default: the read port returns the old value until the edge.
  - With bypass compiled in: see Configuration.
- No handshake; each enable is sampled once per edge.

## Configuration

- Macro: REG_FILE_BYPASS_EN.
- Defined: write-to-read bypass is enabled. When RegWrite_i = 1, RDaddr_i ≠ 0 and a read address equals RDaddr_i, that read port returns RDdata_i in the same cycle. Reads of register 0 still return 0.
- Undefined: no bypass. Reads return only the stored contents.

## Structure

- Shared package reg_file_pkg holds:
  - REG_ADDR_W = 5 and REG_NUM = 32.
  - SP_IDX = 29 and ZERO_IDX = 0.
  - Flag bit indices: N_BIT = 3, Z_BIT = 2, C_BIT = 1, V_BIT = 0.
- One sub-module, nzcv_flag_reg: the 4-bit enabled flag register with asynchronous clear, instantiated once.
- The register array and read multiplexing stay in the top module.

## Test plan

- Reset: assert rst_i mid-cycle. Register 29 reads 32'd128, registers 1 and 31 read 0, and NZCV_o = 0 immediately, without waiting for a clock edge.
- Basic write/read: write 32'hDEADBEEF to register 5 and 32'h1 to register 6. The next cycle, RSaddr=5 and RTaddr=6 return DEADBEEF and 00000001.
- Register 0: write 32'hFFFFFFFF to register 0 with RegWrite_i = 1. Reading register 0 on either port returns 0 after the edge, and also in the same cycle when bypass is enabled.
- Same-cycle read of a write: write 32'h55 to register 7 while reading register 7, with register 7 holding 32'h11 before the edge.
  - Before the edge: the read returns 32'h11 without bypass, and 32'h55 with REG_FILE_BYPASS_EN defined.
  - After the edge: the read returns 32'h55 in both builds.
- Flags: apply NZCV_i = 4'b1010 with FlagWrite_i = 1; NZCV_o = 1010 after the edge. Then apply NZCV_i = 0101 with FlagWrite_i = 0; NZCV_o stays 1010.
- Reset mid-operation: write 32'h77 to register 29, then pulse rst_i between edges. Register 29 returns to 32'd128 immediately, and a write presented while rst_i is high is not performed.
